// File: rtl/vfd_pkg.sv
// Shared definitions for the VFD drive chain: default frequency word width,
// ramp state encoding and a small elaboration-time helper.
package vfd_pkg;

  localparam int FW_DEF = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCEL = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DECEL = 2'd3
  } ramp_st_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ramp_tick.sv
// Programmable millisecond-period counter: emits a one-cycle tick on the
// strobe that arrives while the count sits at period-1.
module ramp_tick #(
  parameter int PW = 4
) (
  input  logic          clk_sys,
  input  logic          rst_n,
  input  logic          pluse_ms,
  input  logic [PW-1:0] period,
  input  logic          clr,
  output logic          tick
);

  logic [PW-1:0] cnt_r;
  logic          wrap_s;

  assign wrap_s = (cnt_r == (period - PW'(1)));
  assign tick   = pluse_ms && !clr && wrap_s;

  // ms counter; clear wins so a strobe coinciding with a state change is dropped
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (pluse_ms) begin
      cnt_r <= wrap_s ? '0 : (cnt_r + PW'(1));
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/freq_ramp.sv
// Soft-start/soft-stop limiter: slews the PWM frequency word toward the
// operator target at a bounded rate, with an immediate emergency stop.
module freq_ramp
  import vfd_pkg::*;
#(
  parameter int FW     = FW_DEF,
  parameter int STEP   = 1,
  parameter int ACC_MS = 10,
  parameter int DEC_MS = 5,
  parameter int FMAX   = 1000
) (
  input  logic          clk_sys,
  input  logic          rst_n,
  input  logic          pluse_ms,
  input  logic [FW-1:0] freq_tgt,
  input  logic          run,
  input  logic          estop,
  output logic [FW-1:0] freq,
  output logic          at_speed,
  output logic [1:0]    ramp_st
);

  localparam int          PW      = $clog2(max_int(ACC_MS, DEC_MS) + 1);
  localparam logic [FW:0] FMAX_X  = (FW+1)'(FMAX);
  localparam logic [FW:0] STEP_X  = (FW+1)'(STEP);
  localparam logic [FW-1:0] FMAX_F = FW'(FMAX);

  logic [FW-1:0] freq_tgt_r;
  logic          run_r;
  logic          estop_r;
  ramp_st_e      st_r, st_nx_s;
  logic [FW-1:0] freq_r, freq_nx_s;
  logic          at_speed_r;

  logic [FW:0]   tgt_x_s, eff_s, freq_x_s;
  logic [FW:0]   up_diff_s, dn_diff_s, up_dlt_s, dn_dlt_s, up_sum_s, dn_sum_s;
  logic [PW-1:0] period_s;
  logic          clr_s, tick_s;

  // input capture stage
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      freq_tgt_r <= '0;
      run_r      <= 1'b0;
      estop_r    <= 1'b0;
    end else begin
      freq_tgt_r <= freq_tgt;
      run_r      <= run;
      estop_r    <= estop;
    end
  end

  // All ramp arithmetic is one bit wider than the word so nothing can wrap
  assign tgt_x_s   = {1'b0, freq_tgt_r};
  assign eff_s     = run_r ? ((tgt_x_s > FMAX_X) ? FMAX_X : tgt_x_s) : '0;
  assign freq_x_s  = {1'b0, freq_r};
  assign up_diff_s = eff_s - freq_x_s;
  assign dn_diff_s = freq_x_s - eff_s;
  assign up_dlt_s  = (up_diff_s < STEP_X) ? up_diff_s : STEP_X;
  assign dn_dlt_s  = (dn_diff_s < STEP_X) ? dn_diff_s : STEP_X;
  assign up_sum_s  = freq_x_s + up_dlt_s;
  assign dn_sum_s  = freq_x_s - dn_dlt_s;

  // state register
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      st_r <= ST_IDLE;
    end else begin
      st_r <= st_nx_s;
    end
  end

  // next-state selection in priority order
  always_comb begin
    st_nx_s = st_r;
    if (estop_r) begin
      st_nx_s = ST_IDLE;
    end else if (freq_x_s < eff_s) begin
      st_nx_s = ST_ACCEL;
    end else if (freq_x_s > eff_s) begin
      st_nx_s = ST_DECEL;
    end else if (eff_s != '0) begin
      st_nx_s = ST_HOLD;
    end else begin
      st_nx_s = ST_IDLE;
    end
  end

  // Counter only runs while a ramp persists; any transition restarts the period
  assign clr_s    = (st_nx_s != st_r) || (st_r == ST_IDLE) || (st_r == ST_HOLD);
  assign period_s = (st_r == ST_DECEL) ? PW'(DEC_MS) : PW'(ACC_MS);

  ramp_tick #(
    .PW(PW)
  ) u_tick (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .pluse_ms(pluse_ms),
    .period  (period_s),
    .clr     (clr_s),
    .tick    (tick_s)
  );

  // next frequency word; saturation guards are defensive, steps never overshoot
  always_comb begin
    freq_nx_s = freq_r;
    if (estop_r) begin
      freq_nx_s = '0;
    end else if (tick_s) begin
      case (st_r)
        ST_ACCEL: freq_nx_s = (up_sum_s > FMAX_X) ? FMAX_F : up_sum_s[FW-1:0];
        ST_DECEL: freq_nx_s = dn_sum_s[FW] ? '0 : dn_sum_s[FW-1:0];
        default:  freq_nx_s = freq_r;
      endcase
    end else begin
      freq_nx_s = freq_r;
    end
  end

  // frequency and at-speed registers
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      freq_r     <= '0;
      at_speed_r <= 1'b1;
    end else begin
      freq_r     <= freq_nx_s;
      at_speed_r <= (freq_x_s == eff_s) && !estop_r;
    end
  end

  // output drive
  always_comb begin
    freq     = freq_r;
    at_speed = at_speed_r;
    ramp_st  = st_r;
  end

endmodule

// File: tb/tb_freq_ramp.sv
// Directed bench for freq_ramp: a default instance and a STEP=4 instance
// with hand-computed expectations for ramp, reversal, estop, reset and clamp.
module tb_freq_ramp;

  logic       clk_sys = 1'b0;
  logic       rst_n;
  logic       pluse_ms;
  logic [9:0] freq_tgt, freq_tgt4;
  logic       run, run4, estop, estop4;
  logic [9:0] freq, freq4;
  logic       at_speed, at_speed4;
  logic [1:0] ramp_st, ramp_st4;
  logic [9:0] max4 = 10'd0;

  int checks = 0;
  int failures = 0;

  always #5 clk_sys = ~clk_sys;

  freq_ramp u_dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .pluse_ms(pluse_ms),
    .freq_tgt(freq_tgt), .run(run), .estop(estop),
    .freq(freq), .at_speed(at_speed), .ramp_st(ramp_st)
  );

  freq_ramp #(.STEP(4), .ACC_MS(2), .DEC_MS(5)) u_dut4 (
    .clk_sys(clk_sys), .rst_n(rst_n), .pluse_ms(pluse_ms),
    .freq_tgt(freq_tgt4), .run(run4), .estop(estop4),
    .freq(freq4), .at_speed(at_speed4), .ramp_st(ramp_st4)
  );

  always @(posedge clk_sys) if (freq4 > max4) max4 <= freq4;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  // n strobes, each preceded by one idle cycle; ends 1 ns after the last strobe edge
  task automatic pulses(input int n);
    repeat (n) begin
      step(1);
      pluse_ms = 1'b1;
      step(1);
      pluse_ms = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0; pluse_ms = 1'b0;
    freq_tgt = 10'd0; run = 1'b0; estop = 1'b0;
    freq_tgt4 = 10'd0; run4 = 1'b0; estop4 = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(2);
    check_val("rst_freq", freq, 0);
    check_val("rst_st", ramp_st, 0);
    check_val("rst_at", at_speed, 1);

    // accelerate 0 -> 5
    run = 1'b1; freq_tgt = 10'd5;
    step(1);
    check_val("acc_lat1", ramp_st, 0);
    step(1);
    check_val("acc_st", ramp_st, 1);
    for (int k = 1; k <= 5; k++) begin
      pulses(9);
      check_val("acc_pre", freq, k - 1);
      pulses(1);
      check_val("acc_step", freq, k);
      if (k == 5) begin
        check_val("acc_last_st", ramp_st, 1);
        check_val("acc_last_at", at_speed, 0);
        step(1);
        check_val("acc_hold_st", ramp_st, 2);
        check_val("acc_hold_at", at_speed, 1);
      end
    end

    // asynchronous reset mid-ramp at 37
    freq_tgt = 10'd40;
    for (int i = 0; i < 400 && freq != 10'd37; i++) pulses(1);
    check_val("pre_rst", freq, 37);
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_freq", freq, 0);
    check_val("arst_st", ramp_st, 0);
    check_val("arst_at", at_speed, 1);
    step(2);
    rst_n = 1'b1;
    step(2);
    check_val("cold_st", ramp_st, 1);
    pulses(9);
    check_val("cold_pre", freq, 0);
    pulses(1);
    check_val("cold_step", freq, 1);

    // same-direction retarget, then reversal at 3
    freq_tgt = 10'd8;
    pulses(10);
    check_val("rev_up2", freq, 2);
    pulses(10);
    check_val("rev_up3", freq, 3);
    pulses(4);
    freq_tgt = 10'd1;
    step(1);
    check_val("rev_lat1", ramp_st, 1);
    step(1);
    check_val("rev_st", ramp_st, 3);
    pulses(4);
    check_val("rev_clr", freq, 3);
    pulses(1);
    check_val("rev_dn2", freq, 2);
    pulses(5);
    check_val("rev_dn1", freq, 1);
    step(1);
    check_val("rev_hold_st", ramp_st, 2);
    check_val("rev_hold_at", at_speed, 1);

    // estop mid-accel at 400
    freq_tgt = 10'd500;
    for (int i = 0; i < 4500 && freq != 10'd400; i++) pulses(1);
    check_val("pre_estop", freq, 400);
    estop = 1'b1;
    step(1);
    check_val("estop_lat1", freq, 400);
    step(1);
    check_val("estop_freq", freq, 0);
    check_val("estop_st", ramp_st, 0);
    pulses(12);
    check_val("estop_held", freq, 0);
    check_val("estop_at", at_speed, 0);
    freq_tgt = 10'd400; estop = 1'b0;
    step(2);
    check_val("estop_rel_st", ramp_st, 1);
    pulses(9);
    check_val("estop_rel_pre", freq, 0);
    pulses(1);
    check_val("estop_rel_step", freq, 1);

    // STEP=4 instance: up to 10, then partial-step decel to 0
    run4 = 1'b1; freq_tgt4 = 10'd10;
    step(2);
    pulses(5);
    check_val("p4_up8", freq4, 8);
    pulses(1);
    check_val("p4_up10", freq4, 10);
    step(1);
    check_val("p4_hold", ramp_st4, 2);
    run4 = 1'b0;
    step(2);
    check_val("p4_dec_st", ramp_st4, 3);
    pulses(4);
    check_val("p4_dn_pre", freq4, 10);
    pulses(1);
    check_val("p4_dn6", freq4, 6);
    pulses(5);
    check_val("p4_dn2", freq4, 2);
    pulses(5);
    check_val("p4_dn0", freq4, 0);
    step(1);
    check_val("p4_idle_st", ramp_st4, 0);
    check_val("p4_idle_at", at_speed4, 1);

    // clamp at FMAX
    run4 = 1'b1; freq_tgt4 = 10'd1023;
    step(2);
    for (int i = 0; i < 600 && freq4 != 10'd1000; i++) pulses(1);
    pulses(20);
    check_val("clamp_freq", freq4, 1000);
    check_val("clamp_max_ok", {31'd0, (max4 <= 10'd1000)}, 1);
    check_val("clamp_st", ramp_st4, 2);
    check_val("clamp_at", at_speed4, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
